minmax_tracker: RTL and testbench

Streaming reduction stage directly downstream of the signed `slt` comparator. It accepts a framed stream of signed N-bit samples over a valid/ready handshake and tracks the running minimum and maximum, with the index of each, using two `slt` instances as its compare datapath. One result per frame is presented on a registered valid/ready output port. It feeds the result bus / register file side of the datapath.

---
 rtl/minmax_tracker_pkg.sv | 18 +
 rtl/adder_n.sv | 21 ++
 rtl/slt.sv | 33 +++
 rtl/minmax_tracker.sv | 110 +++++++++++
 tb/tb_minmax_tracker.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/minmax_tracker_pkg.sv
// ============================================================================
// Module      : minmax_pkg
// Description : Shared types for the min/max streaming tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package minmax_pkg;

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/adder_n.sv
// ============================================================================
// Module      : adder_n
// Description : N-bit ripple adder with carry-in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    assign sum = a + b + {{(N-1){1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/slt.sv
// ============================================================================
// Module      : slt
// Description : Signed less-than, a < b, via subtraction with overflow fix-up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    logic [N-1:0] w_diff;
    logic         w_ovf;

    adder_n #(.N(N)) u_sub (
        .a   (a),
        .b   (~b),
        .cin (1'b1),
        .sum (w_diff)
    );

    // Subtraction overflows only when operand signs differ and the result
    // sign departs from a; the raw sign bit is then inverted.
    assign w_ovf = (a[N-1] ^ b[N-1]) & (w_diff[N-1] ^ a[N-1]);
    assign lt    = w_diff[N-1] ^ w_ovf;

endmodule

`default_nettype wire

// File: rtl/minmax_tracker.sv
// ============================================================================
// Module      : minmax_tracker
// Description : Per-frame running min/max (with indices) over a signed stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [N-1:0]     out_min,
    output logic [N-1:0]     out_max,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W:0]   out_count,
    output logic             out_overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [CNT_W:0] c_MAX_COUNT = {1'b1, {CNT_W{1'b0}}};

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_accept;
    logic           w_deliver;
    logic           w_min_lt;
    logic           w_max_lt;
    logic           w_upd_min;
    logic           w_upd_max;
    logic           w_close;
    logic           w_ovf_close;
    logic [CNT_W:0] w_count_nxt;

    slt #(.N(N)) u_slt_min (
        .a  (in_data),
        .b  (out_min),
        .lt (w_min_lt)
    );

    slt #(.N(N)) u_slt_max (
        .a  (out_max),
        .b  (in_data),
        .lt (w_max_lt)
    );

    always_comb begin
        in_ready    = (r_state != S_DONE);
        w_accept    = in_valid & in_ready;
        w_deliver   = out_valid & out_ready;
        w_count_nxt = (r_state == S_FIRST) ? {{CNT_W{1'b0}}, 1'b1} : out_count + 1'b1;
        w_upd_min   = w_accept & (r_state == S_ACCUM) & w_min_lt;
        w_upd_max   = w_accept & (r_state == S_ACCUM) & w_max_lt;
        w_ovf_close = ~in_last & (w_count_nxt == c_MAX_COUNT);
        w_close     = in_last | w_ovf_close;
        w_state_nxt = r_state;
        case (r_state)
            S_FIRST, S_ACCUM: if (w_accept) w_state_nxt = w_close ? S_DONE : S_ACCUM;
            S_DONE:           if (w_deliver) w_state_nxt = S_FIRST;
            default:          w_state_nxt = S_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FIRST;
            out_min      <= '0;
            out_max      <= '0;
            out_min_idx  <= '0;
            out_max_idx  <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                out_count    <= w_count_nxt;
                out_overflow <= w_ovf_close;
                if (w_close) out_valid <= 1'b1;
                if (r_state == S_FIRST) begin
                    out_min     <= in_data;
                    out_max     <= in_data;
                    out_min_idx <= '0;
                    out_max_idx <= '0;
                end
            end
            if (w_upd_min) begin
                out_min     <= in_data;
                out_min_idx <= out_count[CNT_W-1:0];
            end
            if (w_upd_max) begin
                out_max     <= in_data;
                out_max_idx <= out_count[CNT_W-1:0];
            end
            if (w_deliver) out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_minmax_tracker.sv
// ============================================================================
// Module      : tb_minmax_tracker
// Description : Self-checking bench for minmax_tracker (CNT_W = 3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minmax_tracker;

    localparam int c_N      = 32;
    localparam int c_CNT_W  = 3;
    localparam int c_MAXLEN = 1 << c_CNT_W;

    logic                clk = 1'b0;
    logic                rst;
    logic [c_N-1:0]      in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [c_N-1:0]      out_min;
    logic [c_N-1:0]      out_max;
    logic [c_CNT_W-1:0]  out_min_idx;
    logic [c_CNT_W-1:0]  out_max_idx;
    logic [c_CNT_W:0]    out_count;
    logic                out_overflow;
    logic                out_valid;
    logic                out_ready;

    minmax_tracker #(.N(c_N), .CNT_W(c_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_min      (out_min),
        .out_max      (out_max),
        .out_min_idx  (out_min_idx),
        .out_max_idx  (out_max_idx),
        .out_count    (out_count),
        .out_overflow (out_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: collect the frame, reduce it when it closes.
    typedef struct {
        logic [31:0] mn;
        logic [31:0] mx;
        int          mni;
        int          mxi;
        int          cnt;
        bit          ovf;
    } res_t;

    logic [31:0] frame_q[$];
    res_t        exp_q[$];
    bit          exp_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            frame_q.delete();
            exp_q.delete();
            exp_valid = 0;
        end else if (exp_valid) begin
            if (out_ready) begin
                exp_valid = 0;
                void'(exp_q.pop_front());
            end
        end else if (in_valid) begin
            frame_q.push_back(in_data);
            if (in_last || frame_q.size() == c_MAXLEN) begin
                res_t r;
                r.mn  = frame_q[0];
                r.mx  = frame_q[0];
                r.mni = 0;
                r.mxi = 0;
                for (int i = 1; i < frame_q.size(); i++) begin
                    if ($signed(frame_q[i]) < $signed(r.mn)) begin r.mn = frame_q[i]; r.mni = i; end
                    if ($signed(frame_q[i]) > $signed(r.mx)) begin r.mx = frame_q[i]; r.mxi = i; end
                end
                r.cnt = frame_q.size();
                r.ovf = !in_last;
                exp_q.push_back(r);
                frame_q.delete();
                exp_valid = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {63'b0, out_valid}, {63'b0, exp_valid});
        chk("in_ready", {63'b0, in_ready}, {63'b0, !exp_valid});
        if (exp_valid && exp_q.size() > 0) begin
            chk("model_min", {32'b0, out_min}, {32'b0, exp_q[0].mn});
            chk("model_max", {32'b0, out_max}, {32'b0, exp_q[0].mx});
            chk("model_min_idx", {61'b0, out_min_idx}, 64'(exp_q[0].mni));
            chk("model_max_idx", {61'b0, out_max_idx}, 64'(exp_q[0].mxi));
            chk("model_count", {60'b0, out_count}, 64'(exp_q[0].cnt));
            chk("model_overflow", {63'b0, out_overflow}, {63'b0, exp_q[0].ovf});
        end
    end

    task automatic send(input logic [31:0] d, input logic l);
        int t = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 64'd1, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_res(input string nm, input logic [31:0] mn, input int mni,
                             input logic [31:0] mx, input int mxi, input int cnt, input bit ovf);
        int t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_valid"}, {63'b0, out_valid}, 64'd1);
        chk({nm, "_min"}, {32'b0, out_min}, {32'b0, mn});
        chk({nm, "_min_idx"}, {61'b0, out_min_idx}, 64'(mni));
        chk({nm, "_max"}, {32'b0, out_max}, {32'b0, mx});
        chk({nm, "_max_idx"}, {61'b0, out_max_idx}, 64'(mxi));
        chk({nm, "_count"}, {60'b0, out_count}, 64'(cnt));
        chk({nm, "_overflow"}, {63'b0, out_overflow}, {63'b0, ovf});
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_valid"}, {63'b0, out_valid}, 64'd0);
        chk({nm, "_ready"}, {63'b0, in_ready}, 64'd1);
        chk({nm, "_outs"}, {out_min | out_max, 25'b0, out_min_idx, out_max_idx, out_count, out_overflow},
            64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        send(32'd5, 0); send(-32'sd3, 0); send(32'd7, 0); send(-32'sd3, 0); send(32'd0, 1);
        chk("latency_valid", {63'b0, out_valid}, 64'd1);
        check_res("frame5", -32'sd3, 1, 32'd7, 2, 5, 0);
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
            chk("hold_min", {32'b0, out_min}, {32'b0, -32'sd3});
        end
        release_result();
        chk("after_deliver_valid", {63'b0, out_valid}, 64'd0);

        send(32'h8000_0000, 0); send(32'h7FFF_FFFF, 1);
        check_res("ext_fwd", 32'h8000_0000, 0, 32'h7FFF_FFFF, 1, 2, 0);
        release_result();
        send(32'h7FFF_FFFF, 0); send(32'h8000_0000, 1);
        check_res("ext_rev", 32'h8000_0000, 1, 32'h7FFF_FFFF, 0, 2, 0);
        release_result();

        send(32'd42, 1);
        check_res("single", 32'd42, 0, 32'd42, 0, 1, 0);
        release_result();

        for (int i = 1; i <= 8; i++) send(32'(i), 0);
        check_res("overflow", 32'd1, 0, 32'd8, 7, 8, 1);
        release_result();
        send(32'd9, 0); send(32'd10, 0); send(32'd11, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midreset");
        send(32'd2, 0); send(32'd1, 1);
        check_res("post_reset", 32'd1, 1, 32'd2, 0, 2, 0);
        release_result();

        out_ready = 1'b1;
        send(32'd3, 0); send(32'd3, 0); send(32'd3, 1);
        send(-32'sd1, 0); send(32'd4, 1);
        send(32'd0, 1);
        for (int i = 7; i >= 0; i--) send(32'(i), i == 0);
        send(-32'sd5, 0); send(32'd6, 0); send(-32'sd7, 0); send(32'd6, 1);
        repeat (4) @(negedge clk);
        chk("model_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
